// File: rtl/axi_tile_id_tagger_pkg.sv
// Shared widths, tile-field layout and the routing-tag builder for the tile ID tagger.
package axi_tile_id_tagger_pkg;
    localparam int AXI_ID_W          = 16;
    localparam int AXI_ADDR_W        = 32;
    localparam int AXI_DATA_W        = 32;
    localparam int AXI_STRB_W        = AXI_DATA_W / 8;
    localparam int AXI_LEN_W         = 8;
    localparam int AXI_SIZE_W        = 3;
    localparam int AXI_RESP_W        = 2;
    localparam int LOG_N_TILES       = 5;
    localparam int RESP_ID_START_DEF = 10;
    localparam int RESP_ID_PCI_DEF   = 15;
    localparam int IDX_MAX_W         = 8;

    typedef logic [AXI_ID_W-1:0]    axi_id_t;
    typedef logic [LOG_N_TILES-1:0] tile_id_t;

    // {PCI=1, tile field, table index}; every other bit is zero
    function automatic axi_id_t tag_id(input tile_id_t tile,
                                       input logic [IDX_MAX_W-1:0] idx,
                                       input int start = RESP_ID_START_DEF,
                                       input int pci   = RESP_ID_PCI_DEF);
        axi_id_t id;
        id = axi_id_t'(idx);
        id = id | (axi_id_t'(tile) << start);
        id = id | (axi_id_t'(1) << pci);
        return id;
    endfunction
endpackage

// File: rtl/axi_tile_id_tagger_table.sv
// Tag table: holds original IDs per index, lowest-free allocation, free and lookup ports.
module axi_tag_table
    import axi_tile_id_tagger_pkg::*;
#(
    parameter int ENTRIES = 8,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int CNT_W  = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_alloc,
    input  logic [AXI_ID_W-1:0] i_alloc_id,
    output logic [IDX_W-1:0]    o_alloc_idx,
    output logic                o_full,
    input  logic                i_free,
    input  logic [IDX_W-1:0]    i_free_idx,
    input  logic [IDX_W-1:0]    i_lookup_idx,
    output logic [AXI_ID_W-1:0] o_lookup_id,
    output logic                o_lookup_busy,
    output logic [ENTRIES-1:0]  o_busy,
    output logic [CNT_W-1:0]    o_count
);
    logic [ENTRIES-1:0]  r_busy;
    logic [ENTRIES-1:0]  w_busy_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [AXI_ID_W-1:0] r_ids [ENTRIES];

    // Allocation looks only at the start-of-cycle busy vector, so a same-cycle free
    // is never handed out until the following cycle.
    always_comb begin
        o_alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) o_alloc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_alloc) w_busy_nxt[o_alloc_idx] = 1'b1;
        if (i_free)  w_busy_nxt[i_free_idx]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= r_count + CNT_W'(i_alloc) - CNT_W'(i_free);
        end
    end

    always_ff @(posedge clk) begin
        if (i_alloc) r_ids[o_alloc_idx] <= i_alloc_id;
    end

    assign o_full        = &r_busy;
    assign o_lookup_id   = r_ids[i_lookup_idx];
    assign o_lookup_busy = r_busy[i_lookup_idx];
    assign o_busy        = r_busy;
    assign o_count       = r_count;
endmodule

// File: rtl/axi_tile_id_tagger.sv
// Per-tile AXI ID tagger: swaps tile IDs for routing tags toward the crossbar and
// restores the original IDs on B/R responses.
module axi_tile_id_tagger
    import axi_tile_id_tagger_pkg::*;
#(
    parameter int TILE_ID       = 0,
    parameter int RESP_ID_START = RESP_ID_START_DEF,
    parameter int RESP_ID_PCI   = RESP_ID_PCI_DEF,
    parameter int RD_ENTRIES    = 8,
    parameter int WR_ENTRIES    = 8,
    localparam int LOG_RD       = $clog2(RD_ENTRIES),
    localparam int LOG_WR       = $clog2(WR_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [AXI_ID_W-1:0]   s_awid,
    input  logic [AXI_ADDR_W-1:0] s_awaddr,
    input  logic [AXI_LEN_W-1:0]  s_awlen,
    input  logic [AXI_SIZE_W-1:0] s_awsize,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [AXI_ID_W-1:0]   s_wid,
    input  logic [AXI_DATA_W-1:0] s_wdata,
    input  logic [AXI_STRB_W-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [AXI_ID_W-1:0]   s_bid,
    output logic [AXI_RESP_W-1:0] s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AXI_ID_W-1:0]   s_arid,
    input  logic [AXI_ADDR_W-1:0] s_araddr,
    input  logic [AXI_LEN_W-1:0]  s_arlen,
    input  logic [AXI_SIZE_W-1:0] s_arsize,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [AXI_ID_W-1:0]   s_rid,
    output logic [AXI_DATA_W-1:0] s_rdata,
    output logic [AXI_RESP_W-1:0] s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [AXI_ID_W-1:0]   m_awid,
    output logic [AXI_ADDR_W-1:0] m_awaddr,
    output logic [AXI_LEN_W-1:0]  m_awlen,
    output logic [AXI_SIZE_W-1:0] m_awsize,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_ID_W-1:0]   m_wid,
    output logic [AXI_DATA_W-1:0] m_wdata,
    output logic [AXI_STRB_W-1:0] m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [AXI_ID_W-1:0]   m_bid,
    input  logic [AXI_RESP_W-1:0] m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [AXI_ID_W-1:0]   m_arid,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic [AXI_LEN_W-1:0]  m_arlen,
    output logic [AXI_SIZE_W-1:0] m_arsize,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [AXI_ID_W-1:0]   m_rid,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic [AXI_RESP_W-1:0] m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [LOG_RD:0]       rd_outstanding,
    output logic [LOG_WR:0]       wr_outstanding,
    output logic                  err_unexp_resp
);
    localparam tile_id_t TILE = tile_id_t'(TILE_ID);

    logic r_m_arvalid, r_m_awvalid, r_m_wvalid, r_s_bvalid, r_s_rvalid, r_err;
    logic w_ar_hs, w_aw_hs, w_w_hs, w_b_hs, w_r_hs, w_b_ok, w_r_ok;
    logic w_rd_full, w_wr_full, w_rd_busy_hit, w_wr_busy_hit;
    logic [LOG_RD-1:0]     w_rd_alloc_idx;
    logic [LOG_WR-1:0]     w_wr_alloc_idx;
    logic [AXI_ID_W-1:0]   w_rd_orig_id, w_wr_orig_id;
    logic [RD_ENTRIES-1:0] w_rd_busy;
    logic [WR_ENTRIES-1:0] w_wr_busy;

    axi_tag_table #(.ENTRIES(RD_ENTRIES)) u_rd_table (
        .clk(clk), .rstn(rstn),
        .i_alloc(w_ar_hs), .i_alloc_id(s_arid), .o_alloc_idx(w_rd_alloc_idx), .o_full(w_rd_full),
        .i_free(w_r_ok && m_rlast), .i_free_idx(m_rid[LOG_RD-1:0]),
        .i_lookup_idx(m_rid[LOG_RD-1:0]), .o_lookup_id(w_rd_orig_id),
        .o_lookup_busy(w_rd_busy_hit), .o_busy(w_rd_busy), .o_count(rd_outstanding)
    );

    axi_tag_table #(.ENTRIES(WR_ENTRIES)) u_wr_table (
        .clk(clk), .rstn(rstn),
        .i_alloc(w_aw_hs), .i_alloc_id(s_awid), .o_alloc_idx(w_wr_alloc_idx), .o_full(w_wr_full),
        .i_free(w_b_ok), .i_free_idx(m_bid[LOG_WR-1:0]),
        .i_lookup_idx(m_bid[LOG_WR-1:0]), .o_lookup_id(w_wr_orig_id),
        .o_lookup_busy(w_wr_busy_hit), .o_busy(w_wr_busy), .o_count(wr_outstanding)
    );

    // W-queue: write-table indices in AW order, one pointer wrap bit to tell full from empty
    logic [LOG_WR:0]   r_wq_wp, r_wq_rp;
    logic [LOG_WR-1:0] r_wq_mem [WR_ENTRIES];
    logic              w_wq_empty, w_wq_full;
    logic [LOG_WR-1:0] w_wq_head;

    assign w_wq_empty = (r_wq_wp == r_wq_rp);
    assign w_wq_full  = (r_wq_wp[LOG_WR] != r_wq_rp[LOG_WR]) &&
                        (r_wq_wp[LOG_WR-1:0] == r_wq_rp[LOG_WR-1:0]);
    assign w_wq_head  = r_wq_mem[r_wq_rp[LOG_WR-1:0]];

    // Handshakes
    assign s_arready = (!r_m_arvalid || m_arready) && !w_rd_full;
    assign s_awready = (!r_m_awvalid || m_awready) && !w_wr_full && !w_wq_full;
    assign s_wready  = (!r_m_wvalid || m_wready) && !w_wq_empty;
    assign m_bready  = !r_s_bvalid || s_bready;
    assign m_rready  = !r_s_rvalid || s_rready;

    assign w_ar_hs = s_arvalid && s_arready;
    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_b_hs  = m_bvalid && m_bready;
    assign w_r_hs  = m_rvalid && m_rready;
    assign w_b_ok  = w_b_hs && w_wr_busy_hit;
    assign w_r_ok  = w_r_hs && w_rd_busy_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_arvalid <= 1'b0;
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_s_bvalid  <= 1'b0;
            r_s_rvalid  <= 1'b0;
            r_err       <= 1'b0;
            r_wq_wp     <= '0;
            r_wq_rp     <= '0;
        end else begin
            if (!r_m_arvalid || m_arready) r_m_arvalid <= w_ar_hs;
            if (!r_m_awvalid || m_awready) r_m_awvalid <= w_aw_hs;
            if (!r_m_wvalid || m_wready)   r_m_wvalid  <= w_w_hs;
            if (m_bready)                  r_s_bvalid  <= w_b_ok;
            if (m_rready)                  r_s_rvalid  <= w_r_ok;
            if ((w_b_hs && !w_wr_busy_hit) || (w_r_hs && !w_rd_busy_hit)) r_err <= 1'b1;
            if (w_aw_hs)             r_wq_wp <= r_wq_wp + 1'b1;
            if (w_w_hs && s_wlast)   r_wq_rp <= r_wq_rp + 1'b1;
        end
    end

    // Payload registers: loaded only on handshake, never reset
    logic [AXI_ID_W-1:0]   r_m_arid, r_m_awid, r_m_wid, r_s_bid, r_s_rid;
    logic [AXI_ADDR_W-1:0] r_m_araddr, r_m_awaddr;
    logic [AXI_LEN_W-1:0]  r_m_arlen, r_m_awlen;
    logic [AXI_SIZE_W-1:0] r_m_arsize, r_m_awsize;
    logic [AXI_DATA_W-1:0] r_m_wdata, r_s_rdata;
    logic [AXI_STRB_W-1:0] r_m_wstrb;
    logic                  r_m_wlast, r_s_rlast;
    logic [AXI_RESP_W-1:0] r_s_bresp, r_s_rresp;

    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            r_m_arid   <= tag_id(TILE, IDX_MAX_W'(w_rd_alloc_idx), RESP_ID_START, RESP_ID_PCI);
            r_m_araddr <= s_araddr;
            r_m_arlen  <= s_arlen;
            r_m_arsize <= s_arsize;
        end
        if (w_aw_hs) begin
            r_m_awid   <= tag_id(TILE, IDX_MAX_W'(w_wr_alloc_idx), RESP_ID_START, RESP_ID_PCI);
            r_m_awaddr <= s_awaddr;
            r_m_awlen  <= s_awlen;
            r_m_awsize <= s_awsize;
            r_wq_mem[r_wq_wp[LOG_WR-1:0]] <= w_wr_alloc_idx;
        end
        if (w_w_hs) begin
            r_m_wid   <= tag_id(TILE, IDX_MAX_W'(w_wq_head), RESP_ID_START, RESP_ID_PCI);
            r_m_wdata <= s_wdata;
            r_m_wstrb <= s_wstrb;
            r_m_wlast <= s_wlast;
        end
        if (w_b_ok) begin
            r_s_bid   <= w_wr_orig_id;
            r_s_bresp <= m_bresp;
        end
        if (w_r_ok) begin
            r_s_rid   <= w_rd_orig_id;
            r_s_rdata <= m_rdata;
            r_s_rresp <= m_rresp;
            r_s_rlast <= m_rlast;
        end
    end

    assign m_arvalid = r_m_arvalid;
    assign m_arid    = r_m_arid;
    assign m_araddr  = r_m_araddr;
    assign m_arlen   = r_m_arlen;
    assign m_arsize  = r_m_arsize;
    assign m_awvalid = r_m_awvalid;
    assign m_awid    = r_m_awid;
    assign m_awaddr  = r_m_awaddr;
    assign m_awlen   = r_m_awlen;
    assign m_awsize  = r_m_awsize;
    assign m_wvalid  = r_m_wvalid;
    assign m_wid     = r_m_wid;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;
    assign m_wlast   = r_m_wlast;
    assign s_bvalid  = r_s_bvalid;
    assign s_bid     = r_s_bid;
    assign s_bresp   = r_s_bresp;
    assign s_rvalid  = r_s_rvalid;
    assign s_rid     = r_s_rid;
    assign s_rdata   = r_s_rdata;
    assign s_rresp   = r_s_rresp;
    assign s_rlast   = r_s_rlast;
    assign err_unexp_resp = r_err;

    // Tile-side wid is replaced by the queue head; upper response-ID bits carry only routing
    logic w_unused;
    assign w_unused = ^{s_wid, m_bid, m_rid, w_rd_busy, w_wr_busy};
endmodule
